itf_wr_fetch: RTL and testbench



---
 rtl/itf_pkg.sv | 17 +
 rtl/itf_ring_credit.sv | 54 +++++
 rtl/itf_wr_fetch.sv | 185 ++++++++++++++++++
 tb/tb_itf_wr_fetch.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/itf_pkg.sv
// itf_pkg: shared types for the off-chip interface write-fetch slice.
// Holds the fetch FSM state encoding and the Occupancy width helper.
package itf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RECV,
        DONE
    } itfState_t;

    // Occupancy must represent RING_DEPTH itself, one bit above an address.
    function automatic int occWidth(input int addrWidth);
        return addrWidth + 1;
    endfunction

endpackage

// File: rtl/itf_ring_credit.sv
// itf_ring_credit: ring write pointer and occupancy/free-space tracker.
// Ports: clk, rst_n (sync, active-high), clr (restart pointer), wrEn,
//   relNum (consumer release), wrPtr, occupancy, freeWords, clampErr.
module itf_ring_credit
    import itf_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int RING_DEPTH = 512,
    parameter int REL_WIDTH  = 4,
    localparam int PW = $clog2(RING_DEPTH),
    localparam int OW = occWidth(ADDR_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 wrEn,
    input  logic [REL_WIDTH-1:0] relNum,
    output logic [PW-1:0]        wrPtr,
    output logic [OW-1:0]        occupancy,
    output logic [OW-1:0]        freeWords,
    output logic                 clampErr
);

    logic [OW-1:0] depth;
    logic [OW-1:0] sum;
    logic [OW-1:0] relExt;
    logic [OW-1:0] occNext;

    always_comb begin
        depth    = OW'(RING_DEPTH);
        sum      = occupancy + OW'(wrEn);
        relExt   = OW'(relNum);
        // Over-release empties the ring rather than wrapping the count.
        clampErr = relExt > sum;
        occNext  = clampErr ? '0 : sum - relExt;
        // Overfull (extra beats) must read as no space, not a huge value.
        freeWords = (occupancy >= depth) ? '0 : depth - occupancy;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wrPtr     <= '0;
            occupancy <= '0;
        end else begin
            occupancy <= occNext;
            if (clr) begin
                wrPtr <= '0;
            end else if (wrEn) begin
                wrPtr <= wrPtr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/itf_wr_fetch.sv
// itf_wr_fetch: per-write-port DRAM fetch controller feeding a GLB ring.
// Ports: CCUITF_* job config, TOPITF_* request/ready, ITFTOP_* beats,
//   SRAM_* bank write, CONS_Release, Occupancy, Done, Err.
module itf_wr_fetch
    import itf_pkg::*;
#(
    parameter int SRAM_WIDTH = 256,
    parameter int ADDR_WIDTH = 16,
    parameter int RING_DEPTH = 512,
    parameter int BURST_MAX  = 64,
    parameter int REL_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  CCUITF_Start,
    input  logic [ADDR_WIDTH-1:0] CCUITF_NumWord,
    input  logic [ADDR_WIDTH-1:0] CCUITF_SramBase,
    input  logic [ADDR_WIDTH-1:0] CCUITF_DramOff,
    output logic                  TOPITF_EmptyFull,
    output logic [ADDR_WIDTH-1:0] TOPITF_ReqNum,
    output logic [ADDR_WIDTH-1:0] TOPITF_Addr,
    input  logic [SRAM_WIDTH-1:0] ITFTOP_Dat,
    input  logic                  ITFTOP_DatVld,
    input  logic                  ITFTOP_DatLast,
    output logic                  TOPITF_DatRdy,
    output logic                  SRAM_WrEn,
    output logic [ADDR_WIDTH-1:0] SRAM_WrAddr,
    output logic [SRAM_WIDTH-1:0] SRAM_WrDat,
    input  logic                  SRAM_WrRdy,
    input  logic [REL_WIDTH-1:0]  CONS_Release,
    output logic [ADDR_WIDTH:0]   Occupancy,
    output logic                  Done,
    output logic                  Err
);

    localparam int PW = $clog2(RING_DEPTH);
    localparam int OW = occWidth(ADDR_WIDTH);

    itfState_t state;
    itfState_t stateNext;

    logic [ADDR_WIDTH-1:0] remain;
    logic [ADDR_WIDTH-1:0] nextOff;
    logic [ADDR_WIDTH-1:0] sramBase;
    logic [ADDR_WIDTH-1:0] reqReg;
    logic [ADDR_WIDTH-1:0] granted;
    logic [ADDR_WIDTH-1:0] beatCnt;
    logic                  err;

    logic [PW-1:0] wrPtr;
    logic [OW-1:0] freeWords;
    logic          clampErr;

    logic                  inReq;
    logic                  inRecv;
    logic                  reqLive;
    logic                  startOk;
    logic                  acc;
    logic                  lastAcc;
    logic                  cntErr;
    logic                  errSet;
    logic [ADDR_WIDTH-1:0] burstNum;
    logic [ADDR_WIDTH-1:0] cntNext;
    logic [ADDR_WIDTH-1:0] remainAfter;
    logic [ADDR_WIDTH-1:0] reqCalc;
    logic [OW-1:0]         lim;

    itf_ring_credit #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .RING_DEPTH(RING_DEPTH),
        .REL_WIDTH (REL_WIDTH)
    ) uRing (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (startOk),
        .wrEn     (acc),
        .relNum   (CONS_Release),
        .wrPtr    (wrPtr),
        .occupancy(Occupancy),
        .freeWords(freeWords),
        .clampErr (clampErr)
    );

    always_comb begin
        inReq         = state == REQ;
        inRecv        = state == RECV;
        reqLive       = inReq && (reqReg != '0);
        startOk       = CCUITF_Start && (state == IDLE);
        TOPITF_DatRdy = (reqLive || inRecv) && SRAM_WrRdy;
        acc           = ITFTOP_DatVld && TOPITF_DatRdy;
        lastAcc       = acc && ITFTOP_DatLast;
        // The grant beat arrives in REQ, before granted is loaded.
        burstNum      = inReq ? reqReg : granted;
        cntNext       = inReq ? ADDR_WIDTH'(1) : beatCnt + ADDR_WIDTH'(1);
        remainAfter   = remain - burstNum;
        cntErr        = lastAcc ? (cntNext != burstNum)
                                : (acc && (cntNext > burstNum));
        errSet        = clampErr || cntErr ||
                        (CCUITF_Start && (state != IDLE));
        lim = freeWords;
        if (OW'(remain) < lim) begin
            lim = OW'(remain);
        end
        if (OW'(BURST_MAX) < lim) begin
            lim = OW'(BURST_MAX);
        end
        reqCalc = ADDR_WIDTH'(lim);
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (CCUITF_Start) begin
                    stateNext = (CCUITF_NumWord == '0) ? DONE : REQ;
                end
            end
            REQ, RECV: begin
                if (lastAcc) begin
                    stateNext = (remainAfter == '0) ? DONE : REQ;
                end else if (acc) begin
                    stateNext = RECV;
                end
            end
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            remain   <= '0;
            nextOff  <= '0;
            sramBase <= '0;
            reqReg   <= '0;
            granted  <= '0;
            beatCnt  <= '0;
            err      <= 1'b0;
        end else begin
            err <= (err && !startOk) || errSet;
            if (startOk) begin
                remain   <= CCUITF_NumWord;
                nextOff  <= CCUITF_DramOff;
                sramBase <= CCUITF_SramBase;
                reqReg   <= '0;
                granted  <= '0;
                beatCnt  <= '0;
            end else begin
                // Size is taken once, then held until the grant beat.
                if (inReq && !reqLive) begin
                    reqReg <= reqCalc;
                end
                if (acc) begin
                    beatCnt <= cntNext;
                    if (inReq) begin
                        granted <= reqReg;
                    end
                end
                if (lastAcc) begin
                    remain  <= remainAfter;
                    nextOff <= nextOff + burstNum;
                    reqReg  <= '0;
                end
            end
        end
    end

    assign TOPITF_ReqNum    = inReq ? reqReg : '0;
    assign TOPITF_Addr      = inReq ? nextOff : '0;
    assign TOPITF_EmptyFull = reqLive && (Occupancy == '0);
    assign SRAM_WrEn        = acc;
    assign SRAM_WrAddr      = sramBase + ADDR_WIDTH'(wrPtr);
    assign SRAM_WrDat       = acc ? ITFTOP_Dat : '0;
    assign Done             = state == DONE;
    assign Err              = err;

endmodule

// File: tb/tb_itf_wr_fetch.sv
// tb_itf_wr_fetch: directed job sequence with randomized beats/releases.
// A word-level ring model supplies every expected value.
module tb_itf_wr_fetch;

    localparam int SW    = 256;
    localparam int AW    = 16;
    localparam int RING  = 512;
    localparam int BURST = 64;
    localparam int RW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          CCUITF_Start;
    logic [AW-1:0] CCUITF_NumWord;
    logic [AW-1:0] CCUITF_SramBase;
    logic [AW-1:0] CCUITF_DramOff;
    logic          TOPITF_EmptyFull;
    logic [AW-1:0] TOPITF_ReqNum;
    logic [AW-1:0] TOPITF_Addr;
    logic [SW-1:0] ITFTOP_Dat;
    logic          ITFTOP_DatVld;
    logic          ITFTOP_DatLast;
    logic          TOPITF_DatRdy;
    logic          SRAM_WrEn;
    logic [AW-1:0] SRAM_WrAddr;
    logic [SW-1:0] SRAM_WrDat;
    logic          SRAM_WrRdy;
    logic [RW-1:0] CONS_Release;
    logic [AW:0]   Occupancy;
    logic          Done;
    logic          Err;

    always #5 clk = ~clk;

    itf_wr_fetch #(
        .SRAM_WIDTH(SW),
        .ADDR_WIDTH(AW),
        .RING_DEPTH(RING),
        .BURST_MAX (BURST),
        .REL_WIDTH (RW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .CCUITF_Start    (CCUITF_Start),
        .CCUITF_NumWord  (CCUITF_NumWord),
        .CCUITF_SramBase (CCUITF_SramBase),
        .CCUITF_DramOff  (CCUITF_DramOff),
        .TOPITF_EmptyFull(TOPITF_EmptyFull),
        .TOPITF_ReqNum   (TOPITF_ReqNum),
        .TOPITF_Addr     (TOPITF_Addr),
        .ITFTOP_Dat      (ITFTOP_Dat),
        .ITFTOP_DatVld   (ITFTOP_DatVld),
        .ITFTOP_DatLast  (ITFTOP_DatLast),
        .TOPITF_DatRdy   (TOPITF_DatRdy),
        .SRAM_WrEn       (SRAM_WrEn),
        .SRAM_WrAddr     (SRAM_WrAddr),
        .SRAM_WrDat      (SRAM_WrDat),
        .SRAM_WrRdy      (SRAM_WrRdy),
        .CONS_Release    (CONS_Release),
        .Occupancy       (Occupancy),
        .Done            (Done),
        .Err             (Err)
    );

    int checks = 0;
    int errors = 0;

    // Model: words in ring, words left, writes this job, next offset.
    int          mOcc;
    int          mRem;
    int          mWr;
    logic [AW-1:0] mOff;
    logic [AW-1:0] mBase;
    logic        mErr;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int min3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        return m;
    endfunction

    function automatic int pickRel(input int mode);
        int cap;
        cap = (mOcc > 15) ? 15 : mOcc;
        if (mode == 1) return int'($urandom_range(0, cap));
        if (mode == 2) return (mOcc == 5) ? 1 : 0;
        return 0;
    endfunction

    task automatic idleIn();
        CCUITF_Start   = 1'b0;
        ITFTOP_DatVld  = 1'b0;
        ITFTOP_DatLast = 1'b0;
        ITFTOP_Dat     = '0;
        SRAM_WrRdy     = 1'b0;
        CONS_Release   = '0;
    endtask

    task automatic checkZero(input string p);
        chk({p, "_reqNum"}, TOPITF_ReqNum, 0);
        chk({p, "_addr"}, TOPITF_Addr, 0);
        chk({p, "_emptyFull"}, TOPITF_EmptyFull, 0);
        chk({p, "_datRdy"}, TOPITF_DatRdy, 0);
        chk({p, "_wrEn"}, SRAM_WrEn, 0);
        chk({p, "_wrAddr"}, SRAM_WrAddr, 0);
        chk({p, "_wrDatZero"}, SRAM_WrDat == '0, 1);
        chk({p, "_occ"}, Occupancy, 0);
        chk({p, "_done"}, Done, 0);
        chk({p, "_err"}, Err, 0);
    endtask

    task automatic startJob(input int num, input logic [AW-1:0] base,
                            input logic [AW-1:0] off);
        CCUITF_Start    = 1'b1;
        CCUITF_NumWord  = AW'(num);
        CCUITF_SramBase = base;
        CCUITF_DramOff  = off;
        tick();
        CCUITF_Start = 1'b0;
        mRem  = num;
        mOff  = off;
        mBase = base;
        mWr   = 0;
        mErr  = 1'b0;
    endtask

    // A request is sized from free space on the first cycle any exists.
    task automatic waitReq(input int relMode, output int got);
        int exp;
        int r;
        exp = -1;
        got = 0;
        for (int c = 0; c < 200; c++) begin
            r = pickRel(relMode);
            CONS_Release = RW'(r);
            #1;
            if (TOPITF_ReqNum != '0) begin
                CONS_Release = '0;
                got = int'(TOPITF_ReqNum);
                break;
            end
            if (exp < 0 && RING - mOcc > 0) begin
                exp = min3(RING - mOcc, mRem, BURST);
            end
            mOcc -= r;
            tick();
            chk("occWait", Occupancy, mOcc);
        end
        CONS_Release = '0;
        chk("reqNum", got, exp);
        chk("reqAddr", TOPITF_Addr, mOff);
    endtask

    task automatic runBurst(input int n, input int lastAt, input int relMode,
                            input int rdyMode);
        logic [SW-1:0] d;
        logic [AW-1:0] ea;
        logic          rdy;
        logic          vld;
        logic          ok;
        int            acc;
        int            cyc;
        int            r;
        acc = 0;
        cyc = 0;
        while (acc < lastAt && cyc < 2000) begin
            cyc++;
            for (int k = 0; k < SW / 32; k++) d[k*32 +: 32] = $urandom;
            vld = ($urandom_range(0, 3) != 0);
            if (rdyMode == 0) rdy = 1'b1;
            else if (rdyMode == 1) rdy = cyc[0];
            else rdy = 1'($urandom_range(0, 1));
            r = pickRel(relMode);
            ITFTOP_Dat     = d;
            ITFTOP_DatVld  = vld;
            ITFTOP_DatLast = (acc == lastAt - 1);
            SRAM_WrRdy     = rdy;
            CONS_Release   = RW'(r);
            #1;
            ok = vld && rdy;
            chk("datRdy", TOPITF_DatRdy, rdy);
            chk("wrEn", SRAM_WrEn, ok);
            if (ok) begin
                ea = mBase + AW'(mWr % RING);
                chk("wrAddr", SRAM_WrAddr, ea);
                chk("wrDat", SRAM_WrDat == d, 1);
                mWr++;
                acc++;
            end
            mOcc = mOcc + int'(ok) - r;
            tick();
            chk("occBurst", Occupancy, mOcc);
        end
        idleIn();
        chk("burstBeats", acc, lastAt);
        if (lastAt != n) mErr = 1'b1;
        mRem -= n;
        mOff += AW'(n);
        chk("errBurst", Err, mErr);
    endtask

    task automatic waitDone();
        int found;
        found = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (Done) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("donePulse", found, 1);
        tick();
        #1;
        chk("doneOneCycle", Done, 0);
    endtask

    task automatic drain(input int target);
        int r;
        for (int c = 0; c < 200 && mOcc > target; c++) begin
            r = (mOcc - target > 15) ? 15 : mOcc - target;
            CONS_Release = RW'(r);
            tick();
            mOcc -= r;
        end
        CONS_Release = '0;
        chk("drainOcc", Occupancy, mOcc);
    endtask

    initial begin
        int got;
        rst_n           = 1'b1;
        CCUITF_NumWord  = '0;
        CCUITF_SramBase = '0;
        CCUITF_DramOff  = '0;
        idleIn();
        mOcc = 0;
        mRem = 0;
        mWr  = 0;
        mOff = '0;
        mBase = '0;
        mErr = 1'b0;
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checkZero("reset");

        // Two requests, 64 then 36; DRAM offset wraps past 16 bits.
        startJob(100, AW'($urandom), 16'hFFE0);
        waitReq(0, got);
        chk("emptyFull", TOPITF_EmptyFull, 1);
        runBurst(got, got, 0, 2);
        waitReq(0, got);
        chk("secondReq36", got, 36);
        chk("emptyFullLow", TOPITF_EmptyFull, 0);
        runBurst(got, got, 0, 2);
        waitDone();
        chk("occAfterA", Occupancy, 100);

        // Fill the ring, stall at full, reopen with a release of 8.
        drain(0);
        startJob(600, AW'($urandom), AW'($urandom));
        for (int k = 0; k < 8; k++) begin
            waitReq(0, got);
            runBurst(got, got, 0, 2);
        end
        chk("occFull", Occupancy, RING);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("noReqFull", TOPITF_ReqNum, 0);
            tick();
        end
        CONS_Release = RW'(8);
        #1;
        chk("noReqRel", TOPITF_ReqNum, 0);
        tick();
        CONS_Release = '0;
        mOcc -= 8;
        waitReq(0, got);
        chk("reqAfterRel8", got, 8);
        runBurst(got, got, 0, 1);
        for (int k = 0; k < 40 && mRem > 0; k++) begin
            waitReq(1, got);
            if (got == 0) break;
            runBurst(got, got, 1, 2);
        end
        waitDone();

        // Early Last: error, full grant charged, next request follows.
        drain(0);
        startJob(100, AW'($urandom), AW'($urandom));
        waitReq(0, got);
        runBurst(got, 10, 0, 2);
        chk("errEarlyLast", Err, 1);
        waitReq(0, got);
        chk("reqAfterShort", got, 36);
        runBurst(got, got, 0, 0);
        waitDone();
        chk("errSticky", Err, 1);

        // Zero-length job; Start while busy flags an error.
        startJob(0, '0, '0);
        #1;
        chk("zeroDone", Done, 1);
        chk("zeroNoReq", TOPITF_ReqNum, 0);
        chk("startClrErr", Err, 0);
        CCUITF_Start = 1'b1;
        tick();
        CCUITF_Start = 1'b0;
        #1;
        chk("busyStartErr", Err, 1);
        chk("busyStartDone", Done, 0);
        startJob(0, '0, '0);
        #1;
        chk("restartClrErr", Err, 0);
        tick();

        // Write plus release at occupancy 5; then over-release.
        drain(0);
        startJob(20, AW'($urandom), AW'($urandom));
        waitReq(0, got);
        runBurst(got, got, 2, 2);
        waitDone();
        drain(5);
        CONS_Release = RW'(7);
        tick();
        CONS_Release = '0;
        mOcc = 0;
        #1;
        chk("clampOcc", Occupancy, 0);
        chk("clampErr", Err, 1);

        // Reset in the middle of a burst.
        startJob(50, AW'($urandom), AW'($urandom));
        waitReq(0, got);
        for (int k = 0; k < 3; k++) begin
            ITFTOP_DatVld = 1'b1;
            SRAM_WrRdy    = 1'b1;
            ITFTOP_Dat    = {8{$urandom}};
            tick();
        end
        #1;
        chk("midRecvOcc", Occupancy, 3);
        rst_n = 1'b1;
        tick();
        #1;
        checkZero("midReset");
        rst_n = 1'b0;
        idleIn();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
